// File: rtl/spi_reg_bank.sv
// SPI (mode 0) slave register bank: one R/W frame per chip-select assertion, serial inputs synchronised into clk.
// Optional readback path enabled by defining SPI_REG_BANK_READBACK_EN.
module spi_reg_bank #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    NUM_REGS    = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sclk,
    input  logic                           COPI,
    input  logic                           cs,
    output logic                           CIPO,
    output logic                           cipo_oe,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic                           wr_strobe,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic                           frame_err
);

    localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W     = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic       r_sclk_meta, r_sclk_sync, r_sclk_dly;
    logic       r_copi_meta, r_copi_sync;
    logic       r_cs_meta, r_cs_sync, r_cs_dly;
    logic [1:0] r_sync_vld;
    logic       r_armed;

    // r_armed only sets once a real (post-reset) high level of cs has been observed,
    // so a cs held low across reset cannot start a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_dly  <= 1'b0;
            r_copi_meta <= 1'b0;
            r_copi_sync <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_dly    <= 1'b1;
            r_sync_vld  <= 2'b00;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_meta <= sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_dly  <= r_sclk_sync;
            r_copi_meta <= COPI;
            r_copi_sync <= r_copi_meta;
            r_cs_meta   <= cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_dly    <= r_cs_sync;
            r_sync_vld  <= {r_sync_vld[0], 1'b1};
            if (r_sync_vld[1] && r_cs_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    logic w_sclk_rise, w_cs_fall, w_cs_rise;
    assign w_sclk_rise = r_sclk_sync & ~r_sclk_dly;
    assign w_cs_fall   = ~r_cs_sync & r_cs_dly;
    assign w_cs_rise   = r_cs_sync & ~r_cs_dly;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [FRAME_LEN-2:0]    r_frame;
    logic [FRAME_LEN-1:0]    w_frame_next;
    logic                    w_in_frame, w_take_bit, w_addr_done, w_frame_done;
    logic                    w_fr_rw, w_addr_hit, w_commit;
    logic [ADDR_WIDTH-1:0]   w_fr_addr;
    logic [DATA_WIDTH-1:0]   w_fr_data;
    logic                    r_wr_strobe, r_frame_err;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

    // The whole frame is shifted into one register; w_frame_next is the frame including the bit sampled now.
    assign w_frame_next = {r_frame, r_copi_sync};
    assign w_in_frame   = (r_state == ST_ADDR) || (r_state == ST_DATA);
    assign w_take_bit   = w_sclk_rise & ~w_cs_rise & w_in_frame;
    assign w_addr_done  = w_take_bit & (r_state == ST_ADDR) & (r_bit_cnt == CNT_W'(ADDR_WIDTH));
    assign w_frame_done = w_take_bit & (r_state == ST_DATA) & (r_bit_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_fr_rw      = w_frame_next[FRAME_LEN-1];
    assign w_fr_addr    = w_frame_next[FRAME_LEN-2 -: ADDR_WIDTH];
    assign w_fr_data    = w_frame_next[DATA_WIDTH-1:0];
    assign w_addr_hit   = {1'b0, w_fr_addr} < (ADDR_WIDTH+1)'(NUM_REGS);
    assign w_commit     = w_frame_done & w_fr_rw & w_addr_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_frame     <= '0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                r_wr_addr <= w_fr_addr;
            end
            r_frame_err <= w_cs_rise & w_in_frame;
            if (w_take_bit) begin
                r_frame   <= w_frame_next[FRAME_LEN-2:0];
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall && r_armed) begin
                        r_state   <= ST_ADDR;
                        r_bit_cnt <= '0;
                    end
                end
                ST_ADDR: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                    end else if (w_addr_done) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                    end else if (w_frame_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_cs_rise) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= RESET_VALUE;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_commit && (w_fr_addr == ADDR_WIDTH'(k))) begin
                    r_regs[k] <= w_fr_data;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
            assign regs_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
        end
    endgenerate

    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign frame_err = r_frame_err;

`ifdef SPI_REG_BANK_READBACK_EN
    logic                  w_sclk_fall;
    logic                  r_rd_req, r_rd_started;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_shift, w_rd_word;
    logic                  r_cipo, r_cipo_oe;

    assign w_sclk_fall = ~r_sclk_sync & r_sclk_dly;

    // Unimplemented addresses fall through the loop and read back as zero.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_rd_addr == ADDR_WIDTH'(k)) begin
                w_rd_word = r_regs[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_req     <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_started <= 1'b0;
            r_rd_shift   <= '0;
            r_cipo       <= 1'b0;
            r_cipo_oe    <= 1'b0;
        end else begin
            if (w_addr_done) begin
                r_rd_req  <= ~w_frame_next[ADDR_WIDTH];
                r_rd_addr <= w_frame_next[ADDR_WIDTH-1:0];
            end
            if (w_cs_rise || (r_state == ST_IDLE)) begin
                r_rd_started <= 1'b0;
                r_cipo_oe    <= 1'b0;
                r_cipo       <= 1'b0;
            end else if ((r_state == ST_DATA) && r_rd_req && w_sclk_fall) begin
                if (!r_rd_started) begin
                    r_rd_started <= 1'b1;
                    r_cipo_oe    <= 1'b1;
                    r_cipo       <= w_rd_word[DATA_WIDTH-1];
                    r_rd_shift   <= w_rd_word << 1;
                end else begin
                    r_cipo     <= r_rd_shift[DATA_WIDTH-1];
                    r_rd_shift <= r_rd_shift << 1;
                end
            end
        end
    end

    assign CIPO    = r_cipo & r_cipo_oe;
    assign cipo_oe = r_cipo_oe;
`else
    assign CIPO    = 1'b0;
    assign cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: random and directed SPI frames against a frame-level register model.
module tb_spi_reg_bank;
    localparam int DW = 8;
    localparam int AW = 7;
    localparam int NR = 5;
    localparam int F  = 1 + AW + DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              copi = 1'b0;
    logic              cs = 1'b1;
    logic              cipo, cipo_oe, wr_strobe, frame_err;
    logic [NR*DW-1:0]  regs_out;
    logic [AW-1:0]     wr_addr;

    spi_reg_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .RESET_VALUE('0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .COPI     (copi),
        .cs       (cs),
        .CIPO     (cipo),
        .cipo_oe  (cipo_oe),
        .regs_out (regs_out),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_cipo = 0;
    bit oe_seen  = 1'b0;

    task automatic check(input string name, input longint unsigned got, input longint unsigned want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    // Reference model: register contents and expected DUT events.
    logic [DW-1:0] mregs [NR];

    typedef struct {
        bit              is_err;
        int              addr;
        logic [NR*DW-1:0] regs;
    } ev_t;
    ev_t           ev_q [$];
    logic [DW-1:0] rd_q [$];

    function automatic logic [NR*DW-1:0] flat();
        logic [NR*DW-1:0] r;
        for (int k = 0; k < NR; k++) r[k*DW +: DW] = mregs[k];
        return r;
    endfunction

    task automatic push_ev(input bit is_err, input int addr);
        ev_t e;
        e.is_err = is_err;
        e.addr   = addr;
        e.regs   = flat();
        ev_q.push_back(e);
    endtask

    // Monitor: write strobes and frame errors.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_strobe) begin
                    if (ev_q.size() == 0) check("unexpected_wr_strobe", 1, 0);
                    else begin
                        e = ev_q.pop_front();
                        $display("txn WR addr=%0d regs=0x%0h", wr_addr, regs_out);
                        check("wr_kind", 0, e.is_err);
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_regs", regs_out, e.regs);
                        check("wr_before_cs_rise", cs, 0);
                    end
                end
                if (frame_err) begin
                    if (ev_q.size() == 0) check("unexpected_frame_err", 1, 0);
                    else begin
                        e = ev_q.pop_front();
                        $display("txn ERR regs=0x%0h", regs_out);
                        check("err_kind", 1, e.is_err);
                        check("err_regs", regs_out, e.regs);
                    end
                end
            end
        end
    end

    // Monitor: controller-side capture of CIPO on sclk rises while driven.
    initial begin
        logic [DW-1:0] word;
        logic [DW-1:0] want;
        int            cnt;
        cnt  = 0;
        word = '0;
        forever begin
            @(posedge sclk or negedge cs);
            if (!sclk) begin
                cnt  = 0;
                word = '0;
            end else if (cipo_oe && cnt < DW) begin
                word = {word[DW-2:0], cipo};
                cnt++;
                if (cnt == DW) begin
                    if (rd_q.size() == 0) check("unexpected_read", 1, 0);
                    else begin
                        want = rd_q.pop_front();
                        $display("txn RD data=0x%0h", word);
                        check("rd_data", word, want);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !cipo_oe && cipo) bad_cipo++;
            if (cipo_oe || cipo) oe_seen = 1'b1;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sclk_bit(input bit b);
        copi = b;
        wait_clk(8);
        sclk = 1'b1;
        wait_clk(8);
        sclk = 1'b0;
    endtask

    task automatic run_frame(input bit rw, input int addr, input int data, input int nsclk);
        logic [F-1:0] fw;
        fw = {rw, AW'(addr), DW'(data)};
        if (nsclk < F) push_ev(1'b1, 0);
        else if (rw) begin
            if (addr < NR) begin
                mregs[addr] = DW'(data);
                push_ev(1'b0, addr);
            end
        end else begin
`ifdef SPI_REG_BANK_READBACK_EN
            rd_q.push_back(addr < NR ? mregs[addr] : '0);
`endif
        end
        oe_seen = 1'b0;
        cs = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nsclk; i++) begin
            sclk_bit(i < F ? fw[F-1-i] : 1'($urandom_range(0, 1)));
        end
        wait_clk(8);
        cs = 1'b1;
        wait_clk(12);
`ifndef SPI_REG_BANK_READBACK_EN
        if (!rw && nsclk >= F) check("read_quiet_when_disabled", oe_seen, 0);
`endif
    endtask

    initial begin
        logic [F-1:0] fw;
        for (int k = 0; k < NR; k++) mregs[k] = '0;

        wait_clk(5);
        check("rst_regs", regs_out, flat());
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_cipo", cipo, 0);
        check("rst_cipo_oe", cipo_oe, 0);
        rst = 1'b0;
        wait_clk(5);

        run_frame(1'b1, 2, 'hA5, F);
        check("write_a5_reg2", regs_out[23:16], 'hA5);
        run_frame(1'b1, 4, 'h3C, F);
        run_frame(1'b0, 4, 0, F);
        run_frame(1'b1, 1, 'h77, 10);
        run_frame(1'b1, 5, 'hEE, F);
        run_frame(1'b0, 5, 0, F);
        run_frame(1'b1, 3, 'h5A, 20);

        // Reset in the middle of the data phase with cs held low.
        fw = {1'b1, 7'd1, 8'h99};
        cs = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 12; i++) sclk_bit(fw[F-1-i]);
        for (int k = 0; k < NR; k++) mregs[k] = '0;
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        check("midrst_regs", regs_out, flat());
        check("midrst_wr_addr", wr_addr, 0);
        for (int i = 0; i < 8; i++) sclk_bit(1'($urandom_range(0, 1)));
        wait_clk(8);
        check("midrst_regs_after_bits", regs_out, flat());
        cs = 1'b1;
        wait_clk(12);
        run_frame(1'b1, 0, 'hC3, F);

        for (int n = 0; n < 30; n++) begin
            int sel, nb;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) nb = int'($urandom_range(1, F - 1));
            else if (sel == 1) nb = int'($urandom_range(F + 1, F + 6));
            else nb = F;
            run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 255)), nb);
        end

        wait_clk(40);
        check("events_drained", ev_q.size(), 0);
        check("reads_drained", rd_q.size(), 0);
        check("cipo_low_without_oe", bad_cipo, 0);
        check("final_regs", regs_out, flat());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
